// File: rtl/clock_digit_source.sv
// HH:MM:SS time-of-day core with push-button set mode; emits the six active-low
// seven-segment codes (seconds units on seg .. hours tens on seg5) for the scanner.
module clock_digit_source #(
    parameter int DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_mode,
    input  logic       btn_min,
    input  logic       btn_hour,
    output logic [6:0] seg,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4,
    output logic [6:0] seg5,
    output logic       sec_tick
);

    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    logic [DIV_W-1:0] div;
    logic [3:0] sec_u, sec_t, min_u, min_t, hr_u, hr_t;
    logic       min_s0, min_s1, min_prev;
    logic       hr_s0, hr_s1, hr_prev;

    logic       tick, min_pulse, hr_pulse;
    logic       sec_last, min_last;
    logic [3:0] min_nu, min_nt, hr_nu, hr_nt;

    assign tick      = (div == DIV_LAST) && !set_mode;
    assign min_pulse = min_s1 && !min_prev;
    assign hr_pulse  = hr_s1 && !hr_prev;
    assign sec_last  = (sec_u == 4'd9) && (sec_t == 4'd5);
    assign min_last  = (min_u == 4'd9) && (min_t == 4'd5);

    // Successor values shared by the carry chain and the adjust buttons.
    always_comb begin
        min_nu = min_u + 4'd1;
        min_nt = min_t;
        if (min_u == 4'd9) begin
            min_nu = 4'd0;
            min_nt = (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
        end
        hr_nu = hr_u + 4'd1;
        hr_nt = hr_t;
        if (hr_t == 4'd2 && hr_u == 4'd3) begin
            hr_nu = 4'd0;
            hr_nt = 4'd0;
        end else if (hr_u == 4'd9) begin
            hr_nu = 4'd0;
            hr_nt = hr_t + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            sec_u    <= '0;
            sec_t    <= '0;
            min_u    <= '0;
            min_t    <= '0;
            hr_u     <= '0;
            hr_t     <= '0;
            min_s0   <= 1'b0;
            min_s1   <= 1'b0;
            min_prev <= 1'b0;
            hr_s0    <= 1'b0;
            hr_s1    <= 1'b0;
            hr_prev  <= 1'b0;
            sec_tick <= 1'b0;
            seg      <= SEG_ZERO;
            seg1     <= SEG_ZERO;
            seg2     <= SEG_ZERO;
            seg3     <= SEG_ZERO;
            seg4     <= SEG_ZERO;
            seg5     <= SEG_ZERO;
        end else begin
            min_s0   <= btn_min;
            min_s1   <= min_s0;
            min_prev <= min_s1;
            hr_s0    <= btn_hour;
            hr_s1    <= hr_s0;
            hr_prev  <= hr_s1;
            sec_tick <= tick;

            if (set_mode || tick) div <= '0;
            else                  div <= div + 1'b1;

            if (tick) begin
                if (sec_u == 4'd9) begin
                    sec_u <= 4'd0;
                    sec_t <= (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
                end else begin
                    sec_u <= sec_u + 4'd1;
                end
                if (sec_last) begin
                    min_u <= min_nu;
                    min_t <= min_nt;
                end
                if (sec_last && min_last) begin
                    hr_u <= hr_nu;
                    hr_t <= hr_nt;
                end
            end else if (set_mode && (min_pulse || hr_pulse)) begin
                // Adjusting either field restarts the current minute.
                sec_u <= 4'd0;
                sec_t <= 4'd0;
                if (min_pulse) begin
                    min_u <= min_nu;
                    min_t <= min_nt;
                end
                if (hr_pulse) begin
                    hr_u <= hr_nu;
                    hr_t <= hr_nt;
                end
            end

            seg  <= seg_encode(sec_u);
            seg1 <= seg_encode(sec_t);
            seg2 <= seg_encode(min_u);
            seg3 <= seg_encode(min_t);
            seg4 <= seg_encode(hr_u);
            seg5 <= seg_encode(hr_t);
        end
    end

endmodule

// File: tb/tb_clock_digit_source.sv
// Bench for clock_digit_source with DIV=4: scoreboarded expectations of the
// displayed HH:MM:SS and sec_tick, plus a table of button-adjust vectors.
module tb_clock_digit_source;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       set_mode;
    logic       btn_min;
    logic       btn_hour;
    logic [6:0] seg, seg1, seg2, seg3, seg4, seg5;
    logic       sec_tick;

    clock_digit_source #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_mode (set_mode),
        .btn_min  (btn_min),
        .btn_hour (btn_hour),
        .seg      (seg),
        .seg1     (seg1),
        .seg2     (seg2),
        .seg3     (seg3),
        .seg4     (seg4),
        .seg5     (seg5),
        .sec_tick (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        string       name;
        logic [41:0] segs;
        logic        tk;
    } exp_t;

    typedef struct {
        int n_min;
        int n_hour;
        int h;
        int m;
        int s;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[4];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [41:0] segs_of(input int h, input int m, input int s);
        return {SEG_TAB[h / 10], SEG_TAB[h % 10], SEG_TAB[m / 10],
                SEG_TAB[m % 10], SEG_TAB[s / 10], SEG_TAB[s % 10]};
    endfunction

    task automatic push_exp(input string name, input int h, input int m, input int s,
                            input logic tk);
        exp_t e;
        e.name = name;
        e.segs = segs_of(h, m, s);
        e.tk   = tk;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [41:0] act;
        act = {seg5, seg4, seg3, seg2, seg1, seg};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expectation queued, segs=%h", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.segs || sec_tick !== e.tk) begin
                failures++;
                $display("FAIL %s: got segs=%h sec_tick=%b, expected segs=%h sec_tick=%b",
                         e.name, act, sec_tick, e.segs, e.tk);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_expect(input string name, input int h, input int m, input int s,
                               input logic tk);
        push_exp(name, h, m, s, tk);
        step();
        pop_check();
    endtask

    task automatic press(input bit is_min, input int n);
        for (int i = 0; i < n; i++) begin
            if (is_min) btn_min = 1'b1; else btn_hour = 1'b1;
            repeat (3) step();
            if (is_min) btn_min = 1'b0; else btn_hour = 1'b0;
            repeat (3) step();
        end
    endtask

    // Called with rst high just after an edge; releases it and follows the first tick.
    task automatic first_tick_seq(input string tag);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k < 5) step_expect($sformatf("%s_edge%0d", tag, k), 0, 0, 0, k == 4);
            else       step_expect($sformatf("%s_edge%0d", tag, k), 0, 0, 1, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{n_min: 0,  n_hour: 23, h: 0,  m: 2,  s: 0};
        tbl[1] = '{n_min: 60, n_hour: 0,  h: 0,  m: 2,  s: 0};
        tbl[2] = '{n_min: 0,  n_hour: 23, h: 23, m: 2,  s: 0};
        tbl[3] = '{n_min: 57, n_hour: 0,  h: 23, m: 59, s: 0};

        rst      = 1'b1;
        set_mode = 1'b0;
        btn_min  = 1'b0;
        btn_hour = 1'b0;
        repeat (3) step();
        push_exp("reset_state", 0, 0, 0, 1'b0);
        pop_check();

        first_tick_seq("first_tick");

        // Held minute button under set mode: one increment, seconds cleared.
        set_mode = 1'b1;
        step();
        btn_min = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 3) step_expect($sformatf("min_hold_%0d", k), 0, 0, 1, 1'b0);
            else        step_expect($sformatf("min_hold_%0d", k), 0, 1, 0, 1'b0);
        end
        btn_min = 1'b0;
        repeat (3) step();

        // Simultaneous minute and hour rise in set mode.
        btn_min  = 1'b1;
        btn_hour = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (k <= 3) step_expect($sformatf("both_set_%0d", k), 0, 1, 0, 1'b0);
            else        step_expect($sformatf("both_set_%0d", k), 1, 2, 0, 1'b0);
        end
        btn_min  = 1'b0;
        btn_hour = 1'b0;
        repeat (3) step();

        // Same stimulus with set mode off: ignored, and first tick DIV edges after exit.
        set_mode = 1'b0;
        btn_min  = 1'b1;
        btn_hour = 1'b1;
        for (int k = 1; k <= 4; k++)
            step_expect($sformatf("both_run_%0d", k), 1, 2, 0, k == 4);
        step_expect("both_run_5", 1, 2, 1, 1'b0);
        set_mode = 1'b1;
        btn_min  = 1'b0;
        btn_hour = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("tbl%0d", i), tbl[i].h, tbl[i].m, tbl[i].s, 1'b0);
            press(1'b1, tbl[i].n_min);
            press(1'b0, tbl[i].n_hour);
            repeat (2) step();
            pop_check();
        end

        // set_mode rising on what would be the tick edge suppresses that tick.
        set_mode = 1'b0;
        repeat (3) step();
        set_mode = 1'b1;
        step_expect("coincident_4", 23, 59, 0, 1'b0);
        step_expect("coincident_5", 23, 59, 0, 1'b0);

        // Run from 23:59:00 through midnight rollover.
        set_mode = 1'b0;
        repeat (236) step();
        step_expect("roll_237", 23, 59, 59, 1'b0);
        step_expect("roll_238", 23, 59, 59, 1'b0);
        step_expect("roll_239", 23, 59, 59, 1'b0);
        step_expect("roll_240", 23, 59, 59, 1'b1);
        step_expect("roll_241", 0, 0, 0, 1'b0);

        // Reset asserted mid-count with divider at 2.
        repeat (3) step();
        step_expect("pre_reset_245", 0, 0, 1, 1'b0);
        step();
        rst = 1'b1;
        #2;
        push_exp("reset_async", 0, 0, 0, 1'b0);
        pop_check();
        step_expect("reset_held", 0, 0, 0, 1'b0);
        first_tick_seq("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
